// File: rtl/zbuffer_scanout_pkg.sv
// Shared types and constants for the double-buffered z-buffer scan-out block.
package zbuffer_scanout_pkg;

  localparam int ADDR_W     = 12;
  localparam int COORD_W    = 6;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/zbuffer_scanout_frame_bank.sv
// Single-port read-first frame RAM with two-cycle registered read latency.
module frame_bank
  import zbuffer_scanout_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_stage_reg;
  logic [WIDTH-1:0] rdata_reg;

  // Read-first: the old contents are captured in the same edge the write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rd_stage_reg <= mem[addr];
    rdata_reg    <= rd_stage_reg;
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/zbuffer_scanout.sv
// Double-buffered frame store: renderer writes the back bank while the front bank is streamed out and cleared.
module zbuffer_scanout
  import zbuffer_scanout_pkg::*;
#(
  parameter int              SIZE     = 64,
  parameter int              WIDTH    = 10,
  parameter logic [WIDTH-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_pixel,
  input  logic               frame_done,
  output logic               zbuf_clear,
  output logic               frame_dropped,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_pixel,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_sof,
  output logic               out_eol
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE * SIZE - 1);

  state_t state_reg, state_next;
  logic bank_sel_reg, pending_reg, zbuf_clear_reg, frame_dropped_reg;
  logic [ADDR_W-1:0] rd_addr_reg, beat_addr_reg;
  logic rd_v1_reg, rd_v2_reg;
  logic [WIDTH-1:0] fifo_mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [2:0] fifo_count_reg;
  logic [2:0] occupancy;
  logic start_swap, rd_issue, push, pop;
  logic [WIDTH-1:0] bank_rdata [2];
  logic [WIDTH-1:0] front_rdata;

  // Reads in flight count against the FIFO so a full pipeline can never overflow it.
  assign occupancy   = fifo_count_reg + 3'(rd_v1_reg) + 3'(rd_v2_reg);
  assign push        = rd_v2_reg;
  assign pop         = out_valid && out_ready;
  assign front_rdata = bank_rdata[bank_sel_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_swap) state_next = ST_SCAN;
      ST_SCAN:  if (rd_issue && rd_addr_reg == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && beat_addr_reg == LAST_ADDR) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_swap = 1'b0;
    rd_issue   = 1'b0;
    case (state_reg)
      ST_IDLE: start_swap = frame_done || pending_reg;
      ST_SCAN: rd_issue   = occupancy < 3'(FIFO_DEPTH);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_reg      <= 1'b0;
      pending_reg       <= 1'b0;
      zbuf_clear_reg    <= 1'b0;
      frame_dropped_reg <= 1'b0;
      rd_addr_reg       <= '0;
      beat_addr_reg     <= '0;
      rd_v1_reg         <= 1'b0;
      rd_v2_reg         <= 1'b0;
    end else begin
      zbuf_clear_reg    <= start_swap;
      frame_dropped_reg <= frame_done && pending_reg;
      rd_v1_reg         <= rd_issue;
      rd_v2_reg         <= rd_v1_reg;
      if (start_swap) begin
        bank_sel_reg  <= ~bank_sel_reg;
        rd_addr_reg   <= '0;
        beat_addr_reg <= '0;
      end else begin
        if (rd_issue) rd_addr_reg <= rd_addr_reg + 1'b1;
        if (pop) beat_addr_reg <= beat_addr_reg + 1'b1;
      end
      if (start_swap) begin
        pending_reg <= 1'b0;
      end else if (frame_done && state_reg != ST_IDLE) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // The front bank is read and cleared by the scan; the other bank takes renderer writes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic              is_front;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic [WIDTH-1:0]  bank_wdata;

    assign is_front   = (bank_sel_reg == 1'(gi));
    assign bank_we    = is_front ? rd_issue : wr_valid;
    assign bank_addr  = is_front ? rd_addr_reg : wr_addr;
    assign bank_wdata = is_front ? BG_COLOR : wr_pixel;

    frame_bank #(
      .DEPTH (SIZE * SIZE),
      .WIDTH (WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      fifo_count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem_reg[fifo_wr_ptr_reg] <= front_rdata;
        fifo_wr_ptr_reg               <= fifo_wr_ptr_reg + 1'b1;
      end
      if (pop) fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
      fifo_count_reg <= fifo_count_reg + 3'(push) - 3'(pop);
    end
  end

  // Beats leave in address order, so a beat counter yields the coordinates.
  assign out_valid     = (fifo_count_reg != '0);
  assign out_pixel     = fifo_mem_reg[fifo_rd_ptr_reg];
  assign out_x         = COORD_W'(beat_addr_reg % ADDR_W'(SIZE));
  assign out_y         = COORD_W'(beat_addr_reg / ADDR_W'(SIZE));
  assign out_sof       = out_valid && (beat_addr_reg == '0);
  assign out_eol       = out_valid && (out_x == COORD_W'(SIZE - 1));
  assign zbuf_clear    = zbuf_clear_reg;
  assign frame_dropped = frame_dropped_reg;

endmodule

// File: tb/tb_zbuffer_scanout.sv
// Directed bench for zbuffer_scanout with a beat scoreboard fed from a model of the back bank.
module tb_zbuffer_scanout;

  localparam int SIZE   = 64;
  localparam int WIDTH  = 10;
  localparam int PIXELS = SIZE * SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_pixel = '0;
  logic frame_done = 1'b0;
  logic out_ready = 1'b0;
  logic zbuf_clear, frame_dropped, out_valid, out_sof, out_eol;
  logic [WIDTH-1:0] out_pixel;
  logic [5:0] out_x, out_y;

  always #5 clk = ~clk;

  zbuffer_scanout #(.SIZE(SIZE), .WIDTH(WIDTH), .BG_COLOR('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_pixel      (wr_pixel),
    .frame_done    (frame_done),
    .zbuf_clear    (zbuf_clear),
    .frame_dropped (frame_dropped),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixel     (out_pixel),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_sof       (out_sof),
    .out_eol       (out_eol)
  );

  typedef struct {
    logic [11:0]      addr;
    logic [WIDTH-1:0] pix;
    logic             care;
  } exp_t;

  exp_t exp_q[$];
  logic [WIDTH-1:0] back_img [PIXELS];
  int checks = 0;
  int errors = 0;
  int beat_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < PIXELS; i++) back_img[i] = '0;
  endtask

  task automatic commit_frame(input logic care);
    exp_t e;
    for (int i = 0; i < PIXELS; i++) begin
      e.addr = 12'(i);
      e.pix  = back_img[i];
      e.care = care;
      exp_q.push_back(e);
    end
    clear_img();
  endtask

  task automatic write_px(input logic [11:0] a, input logic [WIDTH-1:0] p);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_pixel = p;
    back_img[a] = p;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() > 0) exp_q.delete();
    step();
    step();
  endtask

  // Beat monitor: scoreboard pop on each accepted beat, hold check while stalled.
  initial begin
    logic stalled;
    logic [23:0] held, cur;
    exp_t e;
    logic [5:0] ex, ey;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {out_pixel, out_x, out_y, out_sof, out_eol};
      if (rst_n !== 1'b1) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_hold", {7'b0, out_valid, cur}, {7'b0, 1'b1, held});
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ex = 6'(e.addr % 12'(SIZE));
            ey = 6'(e.addr / 12'(SIZE));
            check($sformatf("beat_coord[%0d]", e.addr), {18'b0, out_x, out_y, out_sof, out_eol},
                  {18'b0, ex, ey, (e.addr == 12'd0), (ex == 6'(SIZE - 1))});
            if (e.care) check($sformatf("beat_pixel[%0d]", e.addr), 32'(out_pixel), 32'(e.pix));
          end
          beat_count++;
        end
        stalled = (out_valid === 1'b1) && (out_ready !== 1'b1);
        held = cur;
      end
    end
  end

  initial begin
    int n, base;
    clear_img();
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {8'b0, out_pixel, out_x, out_y, out_sof, out_eol}, 32'd0);
    check("rst_pulses", {30'b0, zbuf_clear, frame_dropped}, 32'd0);
    check("rst_bank_sel", 32'(dut.bank_sel_reg), 32'd0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    // Two unchecked-content frames flush both banks to the background colour.
    commit_frame(1'b0);
    pulse_frame_done();
    wait_drain(6000);
    commit_frame(1'b0);
    pulse_frame_done();
    wait_drain(6000);

    // Frame A: corner pixels, zbuf_clear pulse and first-beat latency.
    write_px(12'd1, 10'h001);
    write_px(12'd4095, 10'h3FF);
    commit_frame(1'b1);
    pulse_frame_done();
    check("clear_pulse_t1", {30'b0, zbuf_clear, out_valid}, {30'b0, 1'b1, 1'b0});
    step();
    check("clear_pulse_t2", {30'b0, zbuf_clear, out_valid}, 32'd0);
    step();
    step();
    check("first_valid_t4", 32'(out_valid), 32'd1);
    wait_drain(6000);

    // Frame C with deferred swap, a dropped frame_done and a write into the next frame.
    write_px(12'd2, 10'h2AA);
    commit_frame(1'b1);
    pulse_frame_done();
    repeat (200) step();
    pulse_frame_done();
    check("no_early_clear", {30'b0, zbuf_clear, frame_dropped}, 32'd0);
    write_px(12'd1, 10'h155);
    pulse_frame_done();
    check("frame_dropped_pulse", 32'(frame_dropped), 32'd1);
    step();
    check("frame_dropped_single", 32'(frame_dropped), 32'd0);
    commit_frame(1'b1);
    wait_drain(12000);

    // Frame E: background expected everywhere; FIFO fills under back-pressure, then toggled ready.
    commit_frame(1'b1);
    out_ready = 1'b0;
    pulse_frame_done();
    repeat (20) step();
    check("fifo_full", 32'(dut.fifo_count_reg), 32'd4);
    check("held_valid", 32'(out_valid), 32'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      out_ready = ~out_ready;
      step();
      n++;
    end
    out_ready = 1'b1;
    wait_drain(10);

    // Reset at beat 100 abandons the frame.
    commit_frame(1'b0);
    pulse_frame_done();
    base = beat_count;
    n = 0;
    while (beat_count < base + 100 && n < 1000) begin
      step();
      n++;
    end
    check("reach_beat100", 32'(beat_count - base), 32'd100);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bank_sel", 32'(dut.bank_sel_reg), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (50) step();
    check("post_rst_idle", {30'b0, out_valid, zbuf_clear}, 32'd0);

    commit_frame(1'b0);
    pulse_frame_done();
    wait_drain(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
